fifo_stream_reader: RTL and testbench

Drain-side controller for the systolic-array FIFO. On a `start` command it pulls exactly `len` words out of a FIFO through the FIFO's `ren`/`empty`/`q_out` read port and re-presents them as a val/rdy output stream. It sits between an input FIFO and a downstream consumer such as a systolic processing element or a serializer. A 2-entry skid buffer absorbs the FIFO's one-cycle registered read latency, so throughput is one word per cycle when the FIFO is non-empty and the consumer is ready.

---
 rtl/fifo_stream_reader.sv | 124 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a counted burst from a FIFO read port into a val/rdy stream
module fifo_stream_reader #(
    parameter int nbits = 16,
    parameter int cbits = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [cbits-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    input  logic             fifo_wen,
    input  logic [nbits-1:0] fifo_q,
    output logic             fifo_ren,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out_msg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [cbits-1:0] remaining;
    logic             inflight;
    logic [1:0]       count;
    logic [nbits-1:0] skid [2];
    logic             head;
    logic             tail;
    logic             deq;
    logic [2:0]       pending;
    logic [2:0]       room;

    assign out_val = (count != 2'd0);
    assign out_msg = out_val ? skid[head] : '0;
    assign deq     = out_val & out_rdy;

    // A word leaving this cycle frees a slot for a read issued this cycle.
    assign pending = {1'b0, count} + {2'b00, inflight};
    assign room    = 3'd2 + {2'b00, deq};

    assign fifo_ren = (state == RUN) && (remaining != '0) && !fifo_empty &&
                      !fifo_wen && (pending < room);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= len;
                        if (len != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fifo_ren) begin
                        remaining <= remaining - cbits'(1);
                    end
                    if (remaining == '0) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Last word must have landed and be leaving (or gone) before completing.
                    if (!inflight && ((count == 2'd0) || ((count == 2'd1) && deq))) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= 1'b0;
            count    <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
            skid[0]  <= '0;
            skid[1]  <= '0;
        end else begin
            inflight <= fifo_ren;
            if (inflight) begin
                skid[tail] <= fifo_q;
                tail       <= ~tail;
            end
            if (deq) begin
                head <= ~head;
            end
            case ({inflight, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed/randomized bench with FIFO model and in-order scoreboard
module tb_fifo_stream_reader;
    localparam int NB = 16;
    localparam int CB = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CB-1:0] len;
    logic          busy;
    logic          done;
    logic          fifo_empty;
    logic          fifo_wen;
    logic [NB-1:0] fifo_q;
    logic          fifo_ren;
    logic          out_val;
    logic          out_rdy;
    logic [NB-1:0] out_msg;
    logic [NB-1:0] wdata;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int base = 0;
    int reads = 0;
    int delivered = 0;
    int at;

    logic [NB-1:0] fq[$];
    logic [NB-1:0] exp_q[$];
    logic          ren_log[$];
    logic          done_log[$];
    logic          busy_log[$];
    logic [NB-1:0] msg_log[$];
    logic [NB-1:0] w[4];

    fifo_stream_reader #(.nbits(NB), .cbits(CB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_wen   (fifo_wen),
        .fifo_q     (fifo_q),
        .fifo_ren   (fifo_ren),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_msg    (out_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] rnd();
        return NB'($urandom);
    endfunction

    function automatic int sum_ren(input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) s += int'(ren_log[i]);
        return s;
    endfunction

    // One clock cycle: sample mid-cycle, score, then advance the FIFO model at the edge.
    task automatic cycle();
        logic [NB-1:0] q_next;
        @(negedge clk);
        ren_log.push_back(fifo_ren);
        done_log.push_back(done);
        busy_log.push_back(busy);
        msg_log.push_back(out_msg);
        if (out_val && out_rdy) begin
            check("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("out_msg", out_msg, exp_q.pop_front());
            delivered++;
        end
        if (fifo_ren) begin
            reads++;
            check("ren_guard", {fifo_wen, fifo_empty}, 0);
            check("outstanding", (reads - delivered) <= 2, 1);
        end
        q_next = '0;
        if (fifo_ren && !fifo_wen && fq.size() != 0) begin
            q_next = fq.pop_front();
        end else if (fifo_wen && !fifo_ren) begin
            fq.push_back(wdata);
            exp_q.push_back(wdata);
        end
        @(posedge clk);
        #1;
        fifo_q = q_next;
        fifo_empty = (fq.size() == 0);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_done(input int limit, output int when);
        when = -1;
        for (int i = 0; i < limit && when < 0; i++) begin
            cycle();
            if (done_log[cyc-1]) when = cyc - 1 - base;
        end
    endtask

    task automatic preload(input logic [NB-1:0] d);
        fq.push_back(d);
        exp_q.push_back(d);
        fifo_empty = 1'b0;
    endtask

    task automatic begin_burst(input int l);
        start = 1'b1;
        len = CB'(l);
        base = cyc;
        reads = 0;
        delivered = 0;
        cycle();
        start = 1'b0;
    endtask

    // Asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ren", fifo_ren, 0);
        check("rst_val", out_val, 0);
        check("rst_msg", out_msg, 0);
        fq.delete();
        exp_q.delete();
        fifo_q = '0;
        fifo_empty = 1'b1;
        fifo_wen = 1'b0;
        start = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        reads = 0;
        delivered = 0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        fifo_empty = 1'b1;
        fifo_wen = 1'b0;
        fifo_q = '0;
        out_rdy = 1'b1;
        wdata = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Basic drain with fixed words
        preload(16'h0011);
        preload(16'h0022);
        preload(16'h0033);
        begin_burst(3);
        run(7);
        for (int c = 1; c <= 4; c++)
            check($sformatf("t1_ren_c%0d", c), ren_log[base+c], (c <= 3) ? 1 : 0);
        check("t1_msg_c3", msg_log[base+3], 16'h0011);
        check("t1_msg_c4", msg_log[base+4], 16'h0022);
        check("t1_msg_c5", msg_log[base+5], 16'h0033);
        check("t1_busy_c1", busy_log[base+1], 1);
        check("t1_done_c5", done_log[base+5], 0);
        check("t1_done_c6", done_log[base+6], 1);
        check("t1_busy_c6", busy_log[base+6], 0);
        check("t1_done_c7", done_log[base+7], 0);
        check("t1_left", exp_q.size(), 0);

        // Backpressure: consumer stalled for six cycles
        do_reset();
        for (int i = 0; i < 4; i++) preload(rnd());
        out_rdy = 1'b0;
        begin_burst(4);
        run(6);
        out_rdy = 1'b1;
        wait_done(20, at);
        check("t2_stall_reads", sum_ren(base + 1, base + 6), 2);
        check("t2_done_seen", at > 0, 1);
        check("t2_delivered", delivered, 4);
        check("t2_reads", reads, 4);
        check("t2_left", exp_q.size(), 0);

        // Writer priority pulse in cycle 2
        do_reset();
        for (int i = 0; i < 3; i++) preload(rnd());
        begin_burst(3);
        cycle();
        fifo_wen = 1'b1;
        wdata = rnd();
        cycle();
        fifo_wen = 1'b0;
        wait_done(20, at);
        check("t3_ren_c1", ren_log[base+1], 1);
        check("t3_ren_c2", ren_log[base+2], 0);
        check("t3_ren_c3", ren_log[base+3], 1);
        check("t3_ren_c4", ren_log[base+4], 1);
        check("t3_done_at", at, 7);
        check("t3_delivered", delivered, 3);
        check("t3_left", exp_q.size(), 1);

        // Empty FIFO at start; words arrive five cycles later
        do_reset();
        begin_burst(2);
        run(4);
        fifo_wen = 1'b1;
        wdata = rnd();
        cycle();
        wdata = rnd();
        cycle();
        fifo_wen = 1'b0;
        wait_done(20, at);
        check("t4_no_ren_empty", sum_ren(base + 1, base + 6), 0);
        check("t4_ren_c7", ren_log[base+7], 1);
        check("t4_done_at", at, 11);
        check("t4_delivered", delivered, 2);
        check("t4_left", exp_q.size(), 0);

        // Zero-length burst
        do_reset();
        preload(rnd());
        begin_burst(0);
        run(3);
        check("t5_done_c1", done_log[base+1], 1);
        check("t5_done_c2", done_log[base+2], 0);
        check("t5_busy_c1", busy_log[base+1], 0);
        check("t5_no_ren", sum_ren(base, base + 3), 0);
        check("t5_left", exp_q.size(), 1);

        // start during RUN is ignored
        do_reset();
        for (int i = 0; i < 5; i++) preload(rnd());
        begin_burst(3);
        cycle();
        start = 1'b1;
        len = CB'(1);
        cycle();
        start = 1'b0;
        wait_done(20, at);
        check("t6_done_at", at, 6);
        check("t6_reads", reads, 3);
        check("t6_delivered", delivered, 3);
        run(3);
        check("t6_no_restart", sum_ren(cyc - 3, cyc - 1), 0);
        check("t6_left", exp_q.size(), 2);

        // Asynchronous reset mid-burst, then a one-word burst
        do_reset();
        for (int i = 0; i < 4; i++) preload(rnd());
        begin_burst(4);
        run(3);
        do_reset();
        w[0] = rnd();
        preload(w[0]);
        begin_burst(1);
        wait_done(10, at);
        check("t7_done_at", at, 4);
        check("t7_msg_c3", msg_log[base+3], w[0]);
        check("t7_delivered", delivered, 1);
        check("t7_left", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
